booth_mul_seq: RTL and testbench

Parametrised sequential radix-4 Booth multiplier. It is the successor of the fixed 8-bit Booth controller/datapath pair, with the controller and datapath merged into one block. It multiplies two WIDTH-bit operands, either both signed or both unsigned, one radix-4 digit per clock, and returns a 2*WIDTH-bit product. It sits between an operand source using a start/ready handshake and a result consumer that samples on a one-cycle done pulse.

---
 rtl/booth_mul_pkg.sv | 24 ++
 rtl/booth_recode.sv | 20 ++
 rtl/booth_mul_seq.sv | 114 +++++++++++
 tb/tb_booth_mul_seq.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_mul_pkg.sv
// Shared types for the sequential radix-4 Booth multiplier: FSM states,
// recoded digit operations and the digit-count helper.
package booth_mul_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  typedef enum logic [2:0] {
    ZERO,
    PLUS1,
    PLUS2,
    MINUS1,
    MINUS2
  } digit_op_e;

  // Unsigned operands need one extra digit to consume the zero-extended top bits.
  function automatic int unsigned num_digits(input int unsigned width, input logic signed_mode);
    return signed_mode ? (width / 2) : (width / 2 + 1);
  endfunction

endpackage

// File: rtl/booth_recode.sv
// Radix-4 Booth recoder: maps the window {Q[2k+1], Q[2k], Q[2k-1]} to a digit operation.
module booth_recode
  import booth_mul_pkg::*;
(
  input  logic [2:0] window,
  output digit_op_e  op
);

  always_comb begin
    op = ZERO;
    case (window)
      3'b001, 3'b010: op = PLUS1;
      3'b011:         op = PLUS2;
      3'b100:         op = MINUS2;
      3'b101, 3'b110: op = MINUS1;
      default:        op = ZERO;
    endcase
  end

endmodule

// File: rtl/booth_mul_seq.sv
// Sequential radix-4 Booth multiplier, one digit per clock, signed or unsigned operands.
// Optional early exit when all remaining digits are zero: define BOOTH_MUL_EARLY_EXIT_EN.
module booth_mul_seq
  import booth_mul_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 ready,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned NMAX = WIDTH / 2 + 1;
  localparam int unsigned UW   = WIDTH + 3;
  localparam int unsigned AW   = UW + 2 * NMAX;
  localparam int unsigned KW   = $clog2(NMAX + 1);

  state_e                   state;
  logic signed [WIDTH+1:0]  m;
  logic signed [WIDTH+2:0]  q;
  logic signed [AW-1:0]     acc;
  logic signed [AW-1:0]     acc_next;
  logic        [KW-1:0]     k;
  logic        [KW-1:0]     n_digits;
  logic                     mode_r;

  digit_op_e                op;
  logic signed [UW-1:0]     m_x;
  logic signed [UW-1:0]     addend;
  logic signed [UW-1:0]     upper_sum;
  logic        [KW:0]       shamt;
  logic                     exit_now;
  logic                     last;

  assign ready = (state == IDLE);
  assign done  = (state == DONE);

  // q is shifted right by 2 each digit, so the current window always sits in q[2:0].
  booth_recode u_recode (
    .window (q[2:0]),
    .op     (op)
  );

`ifdef BOOTH_MUL_EARLY_EXIT_EN
  // Arithmetic shifting replicates the top bit, so "all remaining Q bits equal" is just all-0 or all-1.
  assign exit_now = (q == '0) || (q == '1);
`else
  assign exit_now = 1'b0;
`endif

  always_comb begin
    m_x       = {m[WIDTH+1], m};
    addend    = '0;
    case (op)
      PLUS1:   addend = m_x;
      PLUS2:   addend = {m, 1'b0};
      MINUS1:  addend = -m_x;
      MINUS2:  addend = -{m, 1'b0};
      default: addend = '0;
    endcase
    upper_sum = acc[AW-1 -: UW] + addend;
    shamt     = {n_digits - k, 1'b0};
    // Skipping zero digits is just the shifts they would have done.
    if (exit_now) acc_next = acc >>> shamt;
    else          acc_next = $signed({upper_sum, acc[AW-UW-1:0]}) >>> 2;
    last      = exit_now || (k == n_digits - KW'(1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      m        <= '0;
      q        <= '0;
      acc      <= '0;
      k        <= '0;
      n_digits <= '0;
      mode_r   <= 1'b0;
      product  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            m        <= signed_mode ? {{2{a[WIDTH-1]}}, a} : {2'b00, a};
            q        <= signed_mode ? {{2{b[WIDTH-1]}}, b, 1'b0} : {2'b00, b, 1'b0};
            acc      <= '0;
            k        <= '0;
            n_digits <= KW'(num_digits(WIDTH, signed_mode));
            mode_r   <= signed_mode;
            state    <= CALC;
          end
        end
        CALC: begin
          acc <= acc_next;
          q   <= q >>> 2;
          k   <= k + KW'(1);
          if (last) begin
            state <= DONE;
            // Signed runs use one digit fewer, leaving the result scaled by 4 in acc.
            product <= mode_r ? acc_next[2*WIDTH+1:2] : acc_next[2*WIDTH-1:0];
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mul_seq.sv
// Self-checking bench for booth_mul_seq: directed vector table, handshake/reset
// sequences on WIDTH=8, and a reference-multiply sweep on WIDTH=8 and WIDTH=16.
module tb_booth_mul_seq;

  logic        clk = 1'b0;
  logic        rst8, rst16;
  logic        start8, mode8, ready8, done8;
  logic [7:0]  a8, b8;
  logic [15:0] prod8;
  logic        start16, mode16, ready16, done16;
  logic [15:0] a16, b16;
  logic [31:0] prod16;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  booth_mul_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst8), .start(start8), .signed_mode(mode8),
    .a(a8), .b(b8), .ready(ready8), .done(done8), .product(prod8)
  );

  booth_mul_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst16), .start(start16), .signed_mode(mode16),
    .a(a16), .b(b16), .ready(ready16), .done(done16), .product(prod16)
  );

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        sm;
    logic [15:0] prod;
    int          lat;
    int          lat_ee;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic run8(input logic [7:0] ia, input logic [7:0] ib, input logic im,
                      output logic [15:0] p, output int lat);
    int guard = 0;
    @(negedge clk);
    while (!ready8 && guard < 50) begin @(negedge clk); guard++; end
    lat = -1;
    p   = 'x;
    if (!ready8) return;
    start8 = 1'b1; a8 = ia; b8 = ib; mode8 = im;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 0;
    while (!done8 && lat < 40) begin @(posedge clk); #1; lat++; end
    p = prod8;
  endtask

  task automatic run16(input logic [15:0] ia, input logic [15:0] ib, input logic im,
                       output logic [31:0] p, output int lat);
    int guard = 0;
    @(negedge clk);
    while (!ready16 && guard < 50) begin @(negedge clk); guard++; end
    lat = -1;
    p   = 'x;
    if (!ready16) return;
    start16 = 1'b1; a16 = ia; b16 = ib; mode16 = im;
    @(posedge clk); #1;
    start16 = 1'b0;
    lat = 0;
    while (!done16 && lat < 40) begin @(posedge clk); #1; lat++; end
    p = prod16;
  endtask

  function automatic logic [31:0] ref_mul(input logic [15:0] x, input logic [15:0] y,
                                          input logic m, input int unsigned w);
    longint sx, sy, pr;
    sx = longint'(x);
    sy = longint'(y);
    if (m && x[w-1]) sx = sx - (64'sd1 <<< w);
    if (m && y[w-1]) sy = sy - (64'sd1 <<< w);
    pr = sx * sy;
    return 32'(pr & ((64'sd1 <<< (2 * w)) - 1));
  endfunction

  function automatic logic [15:0] corner(input int idx, input int unsigned w);
    logic [15:0] v;
    case (idx)
      0: v = 16'h0000;
      1: v = 16'h0001;
      2: v = 16'hFFFF >> (17 - w);
      3: v = 16'h0001 << (w - 1);
      default: v = 16'hFFFF >> (16 - w);
    endcase
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [15:0] p8;
    logic [31:0] p16;
    int          l8, l16, exp_lat, busy_err, seen;
    logic [15:0] ra8, rb8;
    logic [15:0] ra16, rb16;
    logic        rm;

    vecs[0]  = '{8'hFF, 8'hFF, 1'b0, 16'hFE01, 5, 5};
    vecs[1]  = '{8'h80, 8'h80, 1'b1, 16'h4000, 4, 4};
    vecs[2]  = '{8'hFD, 8'h05, 1'b1, 16'hFFF1, 4, 3};
    vecs[3]  = '{8'd100, 8'd3, 1'b0, 16'h012C, 5, 3};
    vecs[4]  = '{8'h37, 8'h00, 1'b1, 16'h0000, 4, 1};
    vecs[5]  = '{8'd7, 8'd9, 1'b0, 16'h003F, 5, 4};
    vecs[6]  = '{8'd6, 8'd7, 1'b0, 16'h002A, 5, 3};
    vecs[7]  = '{8'h7F, 8'h7F, 1'b1, 16'h3F01, 4, 4};
    vecs[8]  = '{8'h80, 8'h7F, 1'b1, 16'hC080, 4, 4};
    vecs[9]  = '{8'hFF, 8'hFF, 1'b1, 16'h0001, 4, 2};
    vecs[10] = '{8'h01, 8'hFF, 1'b0, 16'h00FF, 5, 5};
    vecs[11] = '{8'h80, 8'h01, 1'b0, 16'h0080, 5, 2};

    start8 = 1'b0; mode8 = 1'b0; a8 = '0; b8 = '0;
    start16 = 1'b0; mode16 = 1'b0; a16 = '0; b16 = '0;
    rst8 = 1'b0; rst16 = 1'b0;
    #1;
    check("reset_ready", ready8, 1'b1);
    check("reset_done", done8, 1'b0);
    check("reset_product", prod8, 16'h0000);
    repeat (2) @(negedge clk);
    rst8 = 1'b1; rst16 = 1'b1;

    for (int i = 0; i < 12; i++) begin
`ifdef BOOTH_MUL_EARLY_EXIT_EN
      exp_lat = vecs[i].lat_ee;
`else
      exp_lat = vecs[i].lat;
`endif
      run8(vecs[i].a, vecs[i].b, vecs[i].sm, p8, l8);
      check($sformatf("vec%0d_product", i), p8, vecs[i].prod);
      check($sformatf("vec%0d_latency", i), l8, exp_lat);
      @(posedge clk); #1;
      check($sformatf("vec%0d_ready_after_done", i), {ready8, done8}, 2'b10);
    end

    // Request held high through the whole operation must only be taken at edge N+2.
    @(negedge clk);
    start8 = 1'b1; a8 = 8'd7; b8 = 8'd9; mode8 = 1'b0;
    @(posedge clk); #1;
    a8 = 8'd2; b8 = 8'd2;
    l8 = 0; busy_err = 0;
    while (!done8 && l8 < 40) begin
      if (ready8) busy_err++;
      @(posedge clk); #1; l8++;
    end
`ifdef BOOTH_MUL_EARLY_EXIT_EN
    check("bp_lat1", l8, 4);
`else
    check("bp_lat1", l8, 5);
`endif
    check("bp_ready_low", busy_err, 0);
    check("bp_prod1", prod8, 16'h003F);
    @(posedge clk); #1;
    check("bp_ready_back", {ready8, done8}, 2'b10);
    @(posedge clk); #1;
    check("bp_accept2", ready8, 1'b0);
    start8 = 1'b0;
    l8 = 0;
    while (!done8 && l8 < 40) begin @(posedge clk); #1; l8++; end
`ifdef BOOTH_MUL_EARLY_EXIT_EN
    check("bp_lat2", l8, 3);
`else
    check("bp_lat2", l8, 5);
`endif
    check("bp_prod2", prod8, 16'h0004);

    // Asynchronous reset in the middle of an operation.
    @(posedge clk); #1;
    @(negedge clk);
    start8 = 1'b1; a8 = 8'd6; b8 = 8'd7; mode8 = 1'b0;
    @(posedge clk); #1;
    start8 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 rst8 = 1'b0;
    #1;
    check("midrst_ready", ready8, 1'b1);
    check("midrst_done", done8, 1'b0);
    check("midrst_product", prod8, 16'h0000);
    @(negedge clk); @(negedge clk);
    rst8 = 1'b1;
    seen = 0;
    repeat (8) begin @(posedge clk); #1; if (done8) seen++; end
    check("midrst_no_done", seen, 0);
    run8(8'd6, 8'd7, 1'b0, p8, l8);
    check("midrst_fresh_prod", p8, 16'h002A);
`ifdef BOOTH_MUL_EARLY_EXIT_EN
    check("midrst_fresh_lat", l8, 3);
`else
    check("midrst_fresh_lat", l8, 5);
`endif

    // Reference sweep: corner grid first, then random operands, both widths in parallel.
    for (int i = 0; i < 5000; i++) begin
      if (i < 50) begin
        rm   = (i >= 25);
        ra8  = corner((i % 25) / 5, 8);
        rb8  = corner(i % 5, 8);
        ra16 = corner((i % 25) / 5, 16);
        rb16 = corner(i % 5, 16);
      end else begin
        rm   = 1'($urandom_range(0, 1));
        ra8  = {8'h00, 8'($urandom)};
        rb8  = {8'h00, 8'($urandom)};
        ra16 = 16'($urandom);
        rb16 = 16'($urandom);
      end
      fork
        run8(ra8[7:0], rb8[7:0], rm, p8, l8);
        run16(ra16, rb16, rm, p16, l16);
      join
      if (l8 < 1 || l8 > 5)
        check($sformatf("sweep8_lat a=%0h b=%0h m=%0b", ra8, rb8, rm), l8, rm ? 4 : 5);
      else
        check($sformatf("sweep8 a=%0h b=%0h m=%0b", ra8, rb8, rm), p8, ref_mul(ra8, rb8, rm, 8) & 32'h0000FFFF);
      if (l16 < 1 || l16 > 9)
        check($sformatf("sweep16_lat a=%0h b=%0h m=%0b", ra16, rb16, rm), l16, rm ? 8 : 9);
      else
        check($sformatf("sweep16 a=%0h b=%0h m=%0b", ra16, rb16, rm), p16, ref_mul(ra16, rb16, rm, 16));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
